// File: rtl/qspi_flash_responder.sv
// rtl/qspi_flash_responder.sv - QSPI Quad Output Fast Read (0x6B) target fed from a byte-wide backing memory.
module qspi_flash_responder #(
  parameter int          ADDR_W    = 24,
  parameter logic [7:0]  CMD_QREAD = 8'h6B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_di,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              busy,
  output logic              bad_cmd
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state;
  logic [2:0]        sclk_sync;
  logic [2:0]        cs_sync;
  logic [1:0]        di_sync;
  logic [22:0]       sreg;
  logic [4:0]        bit_cnt;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        prefetch;
  logic [3:0]        low_nib;
  logic              nib_low;
  logic              rd_pend;

  logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [23:0] shift_in;

  // Stage [2] is only an edge-detect history tap behind the 2-flop synchronizer.
  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign shift_in  = {sreg, di_sync[1]};
  assign busy      = (state != IDLE);

  // cs_sync resets to 0 so a chip select still low after reset cannot look like a fresh falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sclk_sync <= '0;
      cs_sync   <= '0;
      di_sync   <= '0;
      sreg      <= '0;
      bit_cnt   <= '0;
      addr      <= '0;
      prefetch  <= '0;
      low_nib   <= '0;
      nib_low   <= 1'b0;
      rd_pend   <= 1'b0;
      io_out    <= '0;
      io_oe     <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      bad_cmd   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_clk};
      cs_sync   <= {cs_sync[1:0], spi_cs_n};
      di_sync   <= {di_sync[0], spi_di};
      mem_rd    <= 1'b0;
      bad_cmd   <= 1'b0;
      rd_pend   <= mem_rd;
      if (rd_pend) prefetch <= mem_data;

      if (cs_rise) begin
        state   <= IDLE;
        io_oe   <= '0;
        io_out  <= '0;
        bit_cnt <= '0;
        sreg    <= '0;
        nib_low <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
              sreg    <= '0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              sreg    <= shift_in[22:0];
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                if (shift_in[7:0] == CMD_QREAD) begin
                  state <= ADDR;
                end else begin
                  bad_cmd <= 1'b1;
                  state   <= IGNORE;
                end
              end
            end
          end
          ADDR: begin
            if (sclk_rise) begin
              sreg    <= shift_in[22:0];
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd23) begin
                bit_cnt  <= '0;
                addr     <= shift_in[ADDR_W-1:0];
                mem_addr <= shift_in[ADDR_W-1:0];
                mem_rd   <= 1'b1;
                state    <= DUMMY;
              end
            end
          end
          DUMMY: begin
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                io_oe   <= 4'b1111;
                nib_low <= 1'b0;
                state   <= DATA;
              end
            end
          end
          DATA: begin
            // The high-nibble edge consumes the prefetched byte and launches the read of the next one.
            if (sclk_fall) begin
              if (!nib_low) begin
                io_out   <= prefetch[7:4];
                low_nib  <= prefetch[3:0];
                addr     <= addr + ADDR_ONE;
                mem_addr <= addr + ADDR_ONE;
                mem_rd   <= 1'b1;
                nib_low  <= 1'b1;
              end else begin
                io_out  <= low_nib;
                nib_low <= 1'b0;
              end
            end
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// tb/tb_qspi_flash_responder.sv - scoreboard bench for qspi_flash_responder (24-bit and 8-bit address instances).
module tb_qspi_flash_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_clk = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_di = 1'b0;
  logic sel8 = 1'b0;

  always #5 clk = ~clk;

  logic        cs24, cs8;
  logic [3:0]  io_out24, io_oe24, io_out8, io_oe8;
  logic        mem_rd24, mem_rd8, busy24, busy8, bad24, bad8;
  logic [23:0] mem_addr24;
  logic [7:0]  mem_addr8;
  logic [7:0]  mem_data24 = 8'h00;
  logic [7:0]  mem_data8 = 8'h00;

  assign cs24 = sel8 ? 1'b1 : spi_cs_n;
  assign cs8  = sel8 ? spi_cs_n : 1'b1;

  qspi_flash_responder u24 (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(cs24), .spi_di(spi_di),
    .io_out(io_out24), .io_oe(io_oe24), .mem_rd(mem_rd24), .mem_addr(mem_addr24),
    .mem_data(mem_data24), .busy(busy24), .bad_cmd(bad24)
  );

  qspi_flash_responder #(.ADDR_W(8)) u8 (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(cs8), .spi_di(spi_di),
    .io_out(io_out8), .io_oe(io_oe8), .mem_rd(mem_rd8), .mem_addr(mem_addr8),
    .mem_data(mem_data8), .busy(busy8), .bad_cmd(bad8)
  );

  // Backing memory holds memory[i] = i[7:0], one cycle read latency.
  always @(posedge clk) begin
    mem_data24 <= mem_addr24[7:0];
    mem_data8  <= mem_addr8;
  end

  logic [3:0]  io_out_m, io_oe_m;
  logic        mem_rd_m, busy_m, bad_m;
  logic [23:0] mem_addr_m;
  assign io_out_m   = sel8 ? io_out8 : io_out24;
  assign io_oe_m    = sel8 ? io_oe8 : io_oe24;
  assign mem_rd_m   = sel8 ? mem_rd8 : mem_rd24;
  assign mem_addr_m = sel8 ? {16'h0000, mem_addr8} : mem_addr24;
  assign busy_m     = sel8 ? busy8 : busy24;
  assign bad_m      = sel8 ? bad8 : bad24;

  int n_tests = 0;
  int n_fail = 0;
  logic [3:0]  exp_nib[$];
  logic [23:0] exp_addr[$];
  int   bad_cnt = 0;
  logic watch = 1'b0;
  logic oe_seen = 1'b0;
  logic busy_seen = 1'b0;
  logic mem_rd_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Nibble monitor: samples just before the next falling edge, when the driven nibble is settled.
  always @(posedge spi_clk) begin
    repeat (2) @(negedge clk);
    if (io_oe_m == 4'hF) begin
      if (exp_nib.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_nibble: got %0h expected none", io_out_m);
      end else begin
        check("nibble", {28'h0, io_out_m}, {28'h0, exp_nib.pop_front()});
      end
    end
  end

  // Memory-port monitor plus side-condition watchers.
  always @(posedge clk) begin
    #1;
    if (mem_rd_m) begin
      if (mem_rd_prev) begin
        n_tests++;
        n_fail++;
        $display("FAIL mem_rd_back_to_back: got 1 expected 0");
      end
      if (exp_addr.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_mem_rd: got addr %0h expected none", mem_addr_m);
      end else begin
        check("mem_addr", {8'h0, mem_addr_m}, {8'h0, exp_addr.pop_front()});
      end
    end
    mem_rd_prev = mem_rd_m;
    if (bad_m) bad_cnt++;
    if (watch && io_oe_m != 4'h0) oe_seen = 1'b1;
    if (watch && busy_m) busy_seen = 1'b1;
  end

  task automatic sbit(input logic b, input int hold = 2);
    spi_clk = 1'b0;
    spi_di  = b;
    repeat (2) @(negedge clk);
    spi_clk = 1'b1;
    repeat (hold) @(negedge clk);
  endtask

  task automatic sbyte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) sbit(v[i]);
  endtask

  task automatic frame_start();
    spi_clk = 1'b0;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [23:0] a);
    sbyte(8'h6B);
    sbyte(a[23:16]);
    sbyte(a[15:8]);
    sbyte(a[7:0]);
    repeat (8) sbit(1'b0);
  endtask

  task automatic push_nibs(input logic [31:0] nibs, input int n);
    for (int i = n - 1; i >= 0; i--) exp_nib.push_back(nibs[4*i +: 4]);
  endtask

  task automatic push_addrs(input logic [23:0] first, input int n, input int wrap8);
    for (int i = 0; i < n; i++) begin
      if (wrap8 != 0) exp_addr.push_back({16'h0000, 8'(first[7:0] + i[7:0])});
      else exp_addr.push_back(first + 24'(i));
    end
  endtask

  task automatic check_drained(input string name);
    check({name, "_nibbles_left"}, exp_nib.size(), 0);
    check({name, "_reads_left"}, exp_addr.size(), 0);
  endtask

  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL timeout: got no end of stimulus expected end of stimulus");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_io_out", {28'h0, io_out24}, 32'h0);
    check("rst_io_oe", {28'h0, io_oe24}, 32'h0);
    check("rst_mem_rd", {31'h0, mem_rd24}, 32'h0);
    check("rst_mem_addr", {8'h0, mem_addr24}, 32'h0);
    check("rst_busy", {31'h0, busy24}, 32'h0);
    check("rst_bad_cmd", {31'h0, bad24}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Basic read at 0x10: nibbles 1,0,1,1,1,2,1,3 and reads 0x10..0x14.
    push_addrs(24'h10, 5, 0);
    push_nibs(32'h10111213, 8);
    frame_start();
    send_hdr(24'h000010);
    check("t1_busy", {31'h0, busy_m}, 32'h1);
    repeat (8) sbit(1'b0);
    frame_end();
    check_drained("t1");

    // 8-bit address wrap: bytes 0xFF then 0x00, reads 0xFF, 0x00, 0x01.
    sel8 = 1'b1;
    push_addrs(24'hFF, 3, 1);
    push_nibs(32'h0000FF00, 4);
    frame_start();
    send_hdr(24'h0000FF);
    repeat (4) sbit(1'b0);
    frame_end();
    sel8 = 1'b0;
    check_drained("t2");

    // Unsupported opcode 0x03: one bad_cmd pulse, no drive, no reads.
    bad_cnt = 0;
    oe_seen = 1'b0;
    watch = 1'b1;
    frame_start();
    sbyte(8'h03);
    repeat (40) sbit(1'b1);
    check("t3_busy_ignore", {31'h0, busy_m}, 32'h1);
    frame_end();
    watch = 1'b0;
    check("t3_bad_cmd_pulses", bad_cnt, 1);
    check("t3_io_oe_stayed_0", {31'h0, oe_seen}, 32'h0);

    // Abort after 3 nibbles, then a clean frame at 0x20.
    push_addrs(24'h40, 3, 0);
    push_nibs(32'h00000404, 3);
    frame_start();
    send_hdr(24'h000040);
    repeat (3) sbit(1'b0);
    check("t4_io_oe_on", {28'h0, io_oe_m}, 32'hF);
    spi_cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t4_io_oe_off", {28'h0, io_oe_m}, 32'h0);
    check("t4_io_out_off", {28'h0, io_out_m}, 32'h0);
    check("t4_busy_off", {31'h0, busy_m}, 32'h0);
    @(negedge clk);
    spi_clk = 1'b0;
    repeat (4) @(negedge clk);
    push_addrs(24'h20, 2, 0);
    push_nibs(32'h00000020, 2);
    frame_start();
    send_hdr(24'h000020);
    repeat (2) sbit(1'b0);
    frame_end();
    check_drained("t4");

    // Reset pulse during ADDR: the rest of the frame is ignored.
    frame_start();
    sbyte(8'h6B);
    sbyte(8'h00);
    sbit(1'b0);
    sbit(1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy_rst", {31'h0, busy_m}, 32'h0);
    check("t5_io_oe_rst", {28'h0, io_oe_m}, 32'h0);
    check("t5_mem_addr_rst", {8'h0, mem_addr_m}, 32'h0);
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    watch = 1'b1;
    repeat (26) sbit(1'b0);
    watch = 1'b0;
    check("t5_busy_ignored", {31'h0, busy_seen}, 32'h0);
    check("t5_io_oe_ignored", {31'h0, oe_seen}, 32'h0);
    frame_end();
    push_addrs(24'h30, 2, 0);
    push_nibs(32'h00000030, 2);
    frame_start();
    send_hdr(24'h000030);
    repeat (2) sbit(1'b0);
    frame_end();
    check_drained("t5");

    // 50-cycle spi_clk stall inside DATA holds nibble 3 (low half of 0x51).
    push_addrs(24'h50, 5, 0);
    push_nibs(32'h50515253, 8);
    frame_start();
    send_hdr(24'h000050);
    repeat (3) sbit(1'b0);
    sbit(1'b0, 50);
    check("t6_stall_hold", {28'h0, io_out_m}, 32'h1);
    repeat (4) sbit(1'b0);
    frame_end();
    check_drained("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
